// File: rtl/clk_meter_pkg.sv
// ----------------------------------------------------------------------------
// clk_meter_pkg
//   Shared definitions for the clock period meter:
//     CNT_W_DEF  default tick counter / result width (matches divider width)
//     state_e    measurement FSM states
//     sat_inc    saturating increment, used for the phase tick counter
// ----------------------------------------------------------------------------
package clk_meter_pkg;

  localparam int CNT_W_DEF = 28;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  // Increment v by one, holding at max_v. Callers zero-extend narrower counters.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// ----------------------------------------------------------------------------
// sig_edge_sync
//   Brings an asynchronous square wave into the clk_i domain through a
//   SYNC_STAGES-deep flop chain and produces registered single-cycle rise/fall
//   pulses. Both edges see the same latency (SYNC_STAGES+1 cycles), so phase
//   lengths measured from these pulses are exact for a clk_i-synchronous source.
//
//   Ports:
//     clk_i   in   system clock
//     rst_i   in   asynchronous, active-high reset
//     sig_i   in   measured signal, asynchronous to clk_i
//     rise_o  out  1-cycle pulse on a synchronised 0->1 transition
//     fall_o  out  1-cycle pulse on a synchronised 1->0 transition
// ----------------------------------------------------------------------------
module sig_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  // Marks which chain positions hold a real sample since reset. Edges are
  // suppressed until the previous-value flop is filled, so a line that is
  // already high when reset releases is not mistaken for a rising edge.
  logic [SYNC_STAGES:0]   vld_p0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      vld_p0  <= '0;
      prev_p1 <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      // stage p0: synchroniser chain
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_i};
      vld_p0  <= {vld_p0[SYNC_STAGES-1:0], 1'b1};
      // stage p1: previous synchronised value
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      // stage p2: registered edge pulses
      rise_o  <= vld_p0[SYNC_STAGES] &  sync_p0[SYNC_STAGES-1] & ~prev_p1;
      fall_o  <= vld_p0[SYNC_STAGES] & ~sync_p0[SYNC_STAGES-1] &  prev_p1;
    end
  end

endmodule

// File: rtl/clk_period_meter.sv
// ----------------------------------------------------------------------------
// clk_period_meter
//   Measures the high and low phase lengths, in clk_i ticks, of an incoming
//   square wave and reports one (high, low) pair per complete period.
//
//   Optional feature macro: CLK_METER_TIMEOUT_EN
//     defined   - a phase lasting TIMEOUT ticks without an edge raises stuck_o
//                 (held until the next valid_o) and returns the FSM to IDLE.
//     undefined - no timeout; stuck_o stays 0 and the FSM waits indefinitely.
//
//   Ports:
//     clk_i         in   system clock
//     rst_i         in   asynchronous, active-high reset
//     en_i          in   measurement enable; 0 forces IDLE, outputs hold
//     sig_i         in   measured signal, asynchronous to clk_i
//     high_ticks_o  out  last measured high-phase length
//     low_ticks_o   out  last measured low-phase length
//     valid_o       out  1-cycle pulse when a new pair is loaded
//     sat_o         out  either phase of the reported pair saturated
//     stuck_o       out  input-stuck timeout flag
// ----------------------------------------------------------------------------
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2**20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] high_ticks_o,
  output logic [CNT_W-1:0] low_ticks_o,
  output logic             valid_o,
  output logic             sat_o,
  output logic             stuck_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
`ifdef CLK_METER_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), 64'(CNT_MAX)));
  endfunction

  logic             rise, fall;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             phase_sat_q, phase_sat_n;
  logic             hi_sat_q;
  logic [CNT_W-1:0] hi_q;
  logic             hi_load, out_load, stuck_set, timeout_hit;

  sig_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig_i (sig_i),
    .rise_o(rise),
    .fall_o(fall)
  );

  // stage p3: phase FSM and tick counter
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    phase_sat_n = phase_sat_q;
    hi_load     = 1'b0;
    out_load    = 1'b0;
    stuck_set   = 1'b0;
    timeout_hit = TIMEOUT_ON && (cnt_q == TIMEOUT_C);
    if (!en_i) begin
      state_n     = IDLE;
      cnt_n       = '0;
      phase_sat_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A fall here belongs to a period whose start was not seen.
          if (rise) begin
            state_n     = HIGH;
            cnt_n       = CNT_ONE;
            phase_sat_n = 1'b0;
          end
        end
        HIGH, LOW: begin
          if ((state_q == HIGH) ? fall : rise) begin
            hi_load     = (state_q == HIGH);
            out_load    = (state_q == LOW);
            state_n     = (state_q == HIGH) ? LOW : HIGH;
            cnt_n       = CNT_ONE;
            phase_sat_n = 1'b0;
          end else if (timeout_hit) begin
            stuck_set   = 1'b1;
            state_n     = IDLE;
            cnt_n       = '0;
            phase_sat_n = 1'b0;
          end else begin
            cnt_n = cnt_inc(cnt_q);
            if (cnt_q == CNT_MAX) phase_sat_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_sat_q <= 1'b0;
      hi_sat_q    <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      phase_sat_q <= phase_sat_n;
      if (hi_load) hi_sat_q <= phase_sat_q;
    end
  end

  // hi_q is only read after a fall has loaded it in the same measurement.
  always_ff @(posedge clk_i) begin
    if (hi_load) hi_q <= cnt_q;
  end

  // stage p4: output registers, updated only on period completion
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      high_ticks_o <= '0;
      low_ticks_o  <= '0;
      valid_o      <= 1'b0;
      sat_o        <= 1'b0;
      stuck_o      <= 1'b0;
    end else begin
      valid_o <= out_load;
      if (out_load) begin
        high_ticks_o <= hi_q;
        low_ticks_o  <= cnt_q;
        sat_o        <= hi_sat_q | phase_sat_q;
        stuck_o      <= 1'b0;
      end else if (stuck_set) begin
        stuck_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;

  logic        clk = 1'b0;
  logic        rst, en, sig;
  logic [27:0] hi, lo;
  logic        vld, sat, stuck;
  logic [3:0]  hi4, lo4;
  logic        vld4, sat4, stuck4;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [27:0] hi;
    logic [27:0] lo;
    logic        sat;
    int          t;
  } rep_t;

  rep_t q[$];
  rep_t q4[$];
  rep_t mon_r, mon_r4;

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(28), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sig_i(sig),
    .high_ticks_o(hi), .low_ticks_o(lo), .valid_o(vld), .sat_o(sat), .stuck_o(stuck)
  );

  clk_period_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(15)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sig_i(sig),
    .high_ticks_o(hi4), .low_ticks_o(lo4), .valid_o(vld4), .sat_o(sat4), .stuck_o(stuck4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every reported pair, sampled mid-cycle.
  always @(negedge clk) begin
    if (vld) begin
      mon_r.hi = hi; mon_r.lo = lo; mon_r.sat = sat; mon_r.t = cyc;
      q.push_back(mon_r);
    end
    if (vld4) begin
      mon_r4.hi = 28'(hi4); mon_r4.lo = 28'(lo4); mon_r4.sat = sat4; mon_r4.t = cyc;
      q4.push_back(mon_r4);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic lvl, input int n);
    sig = lvl;
    tick(n);
  endtask

  task automatic square(input int h, input int l, input int periods);
    repeat (periods) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(1);
    q.delete();
    q4.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sig = 1'b0;
    tick(3);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_vld", vld, 0);
    chk("rst_sat", sat, 0);
    chk("rst_stuck", stuck, 0);
    rst = 1'b0;
    tick(2);

    // 2/3 divider output
    square(2, 3, 6);
    tick(5);
    chk("t1_count", q.size(), 5);
    for (int i = 0; i < q.size(); i++) begin
      chk("t1_hi", q[i].hi, 2);
      chk("t1_lo", q[i].lo, 3);
      chk("t1_sat", q[i].sat, 0);
      if (i > 0) chk("t1_interval", q[i].t - q[i-1].t, 5);
    end

    // 1/1 then 8/3, never a mixed pair
    restart();
    square(1, 1, 10);
    square(8, 3, 4);
    tick(6);
    chk("t2_count", q.size(), 13);
    for (int i = 0; i < q.size(); i++) begin
      chk("t2_hi", q[i].hi, (i < 10) ? 1 : 8);
      chk("t2_lo", q[i].lo, (i < 10) ? 1 : 3);
      if (i > 0 && i < 10) chk("t2_interval", q[i].t - q[i-1].t, 2);
    end

    // saturation on the 4-bit instance
    restart();
    square(20, 3, 1);
    square(5, 5, 2);
    tick(6);
    chk("t3_wide_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("t3_wide_hi", q[0].hi, 20);
      chk("t3_wide_lo", q[0].lo, 3);
      chk("t3_wide_sat", q[0].sat, 0);
    end
`ifdef CLK_METER_TIMEOUT_EN
    chk("t3_n4_count", q4.size(), 1);
    if (q4.size() == 1) begin
      chk("t3_n4_hi", q4[0].hi, 5);
      chk("t3_n4_lo", q4[0].lo, 5);
      chk("t3_n4_sat", q4[0].sat, 0);
    end
`else
    chk("t3_n4_count", q4.size(), 2);
    if (q4.size() == 2) begin
      chk("t3_n4_hi_sat", q4[0].hi, 15);
      chk("t3_n4_lo_sat", q4[0].lo, 3);
      chk("t3_n4_sat", q4[0].sat, 1);
      chk("t3_n4_hi_next", q4[1].hi, 5);
      chk("t3_n4_lo_next", q4[1].lo, 5);
      chk("t3_n4_sat_next", q4[1].sat, 0);
    end
`endif
    chk("t3_n4_stuck_end", stuck4, 0);

    // stuck-high line
    restart();
    square(4, 4, 2);
    phase(1'b1, 66);
    chk("t4_stuck_early", stuck, 0);
    phase(1'b1, 4);
`ifdef CLK_METER_TIMEOUT_EN
    chk("t4_stuck_set", stuck, 1);
`else
    chk("t4_stuck_set", stuck, 0);
`endif
    chk("t4_hold_hi", hi, 4);
    chk("t4_hold_lo", lo, 4);
    phase(1'b1, 5);
    square(4, 4, 4);
    tick(6);
`ifdef CLK_METER_TIMEOUT_EN
    chk("t4_count", q.size(), 4);
    for (int i = 0; i < q.size(); i++) begin
      chk("t4_hi", q[i].hi, 4);
      chk("t4_lo", q[i].lo, 4);
    end
`else
    chk("t4_count", q.size(), 5);
    for (int i = 0; i < q.size(); i++) begin
      chk("t4_hi", q[i].hi, (i == 2) ? 79 : 4);
      chk("t4_lo", q[i].lo, 4);
    end
`endif
    chk("t4_stuck_end", stuck, 0);

    // reset mid-HIGH
    restart();
    square(3, 3, 2);
    phase(1'b1, 6);
    chk("t5_pre_count", q.size(), 2);
    chk("t5_pre_hi", hi, 3);
    rst = 1'b1;
    #1;
    chk("t5_async_hi", hi, 0);
    chk("t5_async_lo", lo, 0);
    chk("t5_async_vld", vld, 0);
    tick(2);
    rst = 1'b0;
    q.delete();
    phase(1'b1, 2);
    phase(1'b0, 3);
    square(3, 3, 2);
    tick(6);
    chk("t5_count", q.size(), 1);
    if (q.size() == 1) begin
      chk("t5_hi", q[0].hi, 3);
      chk("t5_lo", q[0].lo, 3);
    end

    // enable dropped mid-LOW
    restart();
    square(4, 4, 2);
    phase(1'b1, 4);
    sig = 1'b0;
    tick(2);
    en = 1'b0;
    tick(10);
    chk("t6_off_count", q.size(), 2);
    chk("t6_off_hi", hi, 4);
    chk("t6_off_lo", lo, 4);
    chk("t6_off_vld", vld, 0);
    en = 1'b1;
    tick(3);
    square(4, 4, 3);
    tick(6);
    chk("t6_count", q.size(), 4);
    for (int i = 0; i < q.size(); i++) begin
      chk("t6_hi", q[i].hi, 4);
      chk("t6_lo", q[i].lo, 4);
    end

    // asynchronous edges jittered around a clock edge, nominal 6/6
    restart();
    sig = 1'b0;
    @(posedge clk);
    begin
      time t0, target;
      int  j;
      t0 = $time;
      for (int i = 0; i < 10; i++) begin
        j = int'($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 0) j = -j;
        target = t0 + 20 + time'(i * 60) + time'(j + 10) - 10;
        #(target - $time);
        sig = ~sig;
      end
    end
    tick(8);
    chk("t6_jit_count", q.size(), 4);
    for (int i = 0; i < q.size(); i++) begin
      chk("t6_jit_hi", (q[i].hi >= 5) && (q[i].hi <= 7), 1);
      chk("t6_jit_lo", (q[i].lo >= 5) && (q[i].lo <= 7), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
